fetch_mw: RTL and testbench
===========================

FETCH_MW -- requirements
Module: fetch_mw

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning): I_DATA_WIDTH, 32, instruction width; I_ADDR_WIDTH, 10, instruction address bits; NUM_WARPS, 4, warp contexts (power of two, >=2); WB = $clog2(NUM_WARPS).
REQ-002 The block SHALL have these ports, one clock and one reset, with reset synchronous and active-high (name, direction, width, meaning):
  clk  in  1  clock, all state on rising edge
  rst  in  1  synchronous active-high reset
  we  in  1  instruction-store write enable
  pc_w  in  I_ADDR_WIDTH  write address
  instr_i  in  I_DATA_WIDTH  write data
  start_valid / start_warp / start_pc  in  1 / WB / I_ADDR_WIDTH  activate warp at PC
  done_valid / done_warp  in  1 / WB  deactivate warp
  redir_valid / redir_warp / redir_pc  in  1 / WB / I_ADDR_WIDTH  branch redirect
  out_ready  in  1  decode accepts
  out_valid  out  1  fetched instruction valid
  instr_f  out  I_DATA_WIDTH  instruction
  warp_f  out  WB  owning warp
  pc_f  out  I_ADDR_WIDTH  instruction PC
  pc_p1  out  I_ADDR_WIDTH  pc_f+1
  active_mask  out  NUM_WARPS  per-warp active bits

Function
REQ-003 The block SHALL hold one PC register and one active bit per warp, and a single-read/single-write block RAM with 1-cycle synchronous read.
REQ-004 A warp SHALL be eligible when active and not being redirected or deactivated in the same cycle.
REQ-005 A fetch SHALL issue in cycle t only when we=0, at least one warp is eligible, and (out_valid=0 or out_ready=1).
REQ-006 Warp selection SHALL be round-robin: search starts at last-issued warp+1, modulo NUM_WARPS; after reset the search starts at warp 0.
REQ-007 On issue for warp w, PC[w] SHALL become PC[w]+1 modulo 2^I_ADDR_WIDTH; the result SHALL appear at t+1 with out_valid=1, warp_f=w, pc_f=old PC[w], and pc_p1=pc_f+1 (wrapping).
REQ-008 While out_valid=1 and out_ready=0, instr_f, warp_f, pc_f and pc_p1 SHALL stay stable and no new fetch SHALL issue.
REQ-009 An accepted output (out_valid and out_ready) with no issue in the same cycle SHALL deassert out_valid next cycle.
REQ-010 we=1 SHALL write instr_i to pc_w and suppress issue that cycle; a held output SHALL remain intact.
REQ-011 start_valid SHALL set active[start_warp]=1 and PC=start_pc next cycle, overriding any existing PC of that warp.
REQ-012 done_valid SHALL clear active[done_warp] next cycle.
REQ-013 redir_valid for warp w in cycle t SHALL set PC[w]=redir_pc at t+1, overriding any increment.
REQ-014 A redirect for warp w SHALL also discard any warp-w instruction issued in t, or presented unaccepted in t; that instruction SHALL never be presented or accepted.
REQ-015 Same-warp priority SHALL be start > redirect > increment; done and start on the same warp SHALL leave it active.
REQ-016 active_mask SHALL reflect the registered active bits.

Reset
REQ-017 With rst=1 at a clock edge: all PCs=0, active_mask=0, out_valid=0, pc_f=0, pc_p1=0, warp_f=0, RR pointer=NUM_WARPS-1; RAM contents SHALL be unaffected.
REQ-018 Reset SHALL override all other inputs, including mid-stall, and drop any in-flight fetch.

Configuration
REQ-019 With macro FETCH_PERF_EN defined, the block SHALL add outputs fetch_cnt[31:0] (increments per accepted instruction) and stall_cnt[31:0] (increments per cycle with out_valid=1 and out_ready=0), both reset to 0 and wrapping at 2^32.
REQ-020 Without FETCH_PERF_EN, those ports and counters SHALL be absent, with no other behavioural difference.

Verification
REQ-021 Load 0x11,0x22,0x33 at 0..2; start warp0 pc=0; out_ready=1 -> instr_f 0x11,0x22,0x33 on consecutive cycles, pc_f 0,1,2.
REQ-022 Start warps 0..3 at PCs 0,8,16,24 together -> warp_f sequence 0,1,2,3,0, with pc_f 0,8,16,24,1.
REQ-023 out_ready=0 for 3 cycles with instruction presented -> outputs stable for 3 cycles, no PC advance, stall_cnt=3 when FETCH_PERF_EN is defined.
REQ-024 Warp0 at pc=5, redirect to 40 in the cycle pc=5 issues -> pc=5 never accepted; next warp0 pc_f=40.
REQ-025 Warp at pc=2^I_ADDR_WIDTH-1 -> pc_f=1023, pc_p1=0, next pc_f=0.
REQ-026 rst pulse during a stall -> out_valid=0 and active_mask=0 next cycle; previously loaded RAM data is still readable after restart.

Source files
------------

// File: rtl/fetch_mw.sv
// Multi-warp instruction fetch: per-warp PC/active state, round-robin issue, 1-cycle block RAM read.
// Optional macro FETCH_PERF_EN adds fetch_cnt/stall_cnt performance counters.
module fetch_mw #(
    parameter int I_DATA_WIDTH = 32,
    parameter int I_ADDR_WIDTH = 10,
    parameter int NUM_WARPS    = 4,
    localparam int WB          = $clog2(NUM_WARPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [I_ADDR_WIDTH-1:0] pc_w,
    input  logic [I_DATA_WIDTH-1:0] instr_i,
    input  logic                    start_valid,
    input  logic [WB-1:0]           start_warp,
    input  logic [I_ADDR_WIDTH-1:0] start_pc,
    input  logic                    done_valid,
    input  logic [WB-1:0]           done_warp,
    input  logic                    redir_valid,
    input  logic [WB-1:0]           redir_warp,
    input  logic [I_ADDR_WIDTH-1:0] redir_pc,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [I_DATA_WIDTH-1:0] instr_f,
    output logic [WB-1:0]           warp_f,
    output logic [I_ADDR_WIDTH-1:0] pc_f,
    output logic [I_ADDR_WIDTH-1:0] pc_p1,
    output logic [NUM_WARPS-1:0]    active_mask
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]             fetch_cnt,
    output logic [31:0]             stall_cnt
`endif
);

    logic [I_DATA_WIDTH-1:0] r_mem [2**I_ADDR_WIDTH];
    logic [I_DATA_WIDTH-1:0] r_instr;
    logic [I_ADDR_WIDTH-1:0] r_pc [NUM_WARPS];
    logic [NUM_WARPS-1:0]    r_active;
    logic                    r_valid;
    logic [WB-1:0]           r_warp_f;
    logic [I_ADDR_WIDTH-1:0] r_pc_f;
    logic [I_ADDR_WIDTH-1:0] r_pc_p1;
    logic [WB-1:0]           r_rr;

    logic [NUM_WARPS-1:0]    w_elig;
    logic [WB-1:0]           w_sel;
    logic                    w_found;
    logic                    w_issue;
    logic [I_ADDR_WIDTH-1:0] w_rd_pc;
    logic                    w_redir_hit_out;

    // A warp being redirected or retired this cycle must not issue from its stale PC.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_elig[i] = r_active[i]
                        && !(redir_valid && (redir_warp == WB'(i)))
                        && !(done_valid && (done_warp == WB'(i)));
        end
    end

    // Scan from the farthest candidate back to the nearest so the nearest eligible warp wins.
    always_comb begin
        logic [WB-1:0] idx;
        w_sel   = '0;
        w_found = 1'b0;
        idx     = '0;
        for (int k = NUM_WARPS; k >= 1; k--) begin
            idx = r_rr + WB'(k);
            if (w_elig[idx]) begin
                w_sel   = idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_issue         = !we && w_found && (!r_valid || out_ready);
    assign w_rd_pc         = r_pc[w_sel];
    assign w_redir_hit_out = redir_valid && (redir_warp == r_warp_f);

    // RAM is deliberately left out of reset so program contents survive a restart.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[pc_w] <= instr_i;
        end
        if (w_issue) begin
            r_instr <= r_mem[w_rd_pc];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                r_pc[i] <= '0;
            end
            r_active <= '0;
            r_valid  <= 1'b0;
            r_warp_f <= '0;
            r_pc_f   <= '0;
            r_pc_p1  <= '0;
            r_rr     <= WB'(NUM_WARPS - 1);
        end else begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                if (start_valid && (start_warp == WB'(i))) begin
                    r_active[i] <= 1'b1;
                    r_pc[i]     <= start_pc;
                end else begin
                    if (done_valid && (done_warp == WB'(i))) begin
                        r_active[i] <= 1'b0;
                    end
                    if (redir_valid && (redir_warp == WB'(i))) begin
                        r_pc[i] <= redir_pc;
                    end else if (w_issue && (w_sel == WB'(i))) begin
                        r_pc[i] <= r_pc[i] + 1'b1;
                    end
                end
            end

            // A held instruction whose warp is redirected is squashed before decode can take it.
            if (w_issue) begin
                r_valid  <= 1'b1;
                r_warp_f <= w_sel;
                r_pc_f   <= w_rd_pc;
                r_pc_p1  <= w_rd_pc + 1'b1;
                r_rr     <= w_sel;
            end else if (r_valid && (out_ready || w_redir_hit_out)) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_valid && out_ready) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (r_valid && !out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

    assign out_valid   = r_valid;
    assign instr_f     = r_instr;
    assign warp_f      = r_warp_f;
    assign pc_f        = r_pc_f;
    assign pc_p1       = r_pc_p1;
    assign active_mask = r_active;

endmodule

// File: tb/tb_fetch_mw.sv
// Directed bench for fetch_mw: fetch order, round-robin, stall, redirect squash, PC wrap, reset.
module tb_fetch_mw;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NW = 4;
    localparam int WB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] pc_w;
    logic [DW-1:0] instr_i;
    logic          start_valid;
    logic [WB-1:0] start_warp;
    logic [AW-1:0] start_pc;
    logic          done_valid;
    logic [WB-1:0] done_warp;
    logic          redir_valid;
    logic [WB-1:0] redir_warp;
    logic [AW-1:0] redir_pc;
    logic          out_ready;
    logic          out_valid;
    logic [DW-1:0] instr_f;
    logic [WB-1:0] warp_f;
    logic [AW-1:0] pc_f;
    logic [AW-1:0] pc_p1;
    logic [NW-1:0] active_mask;
`ifdef FETCH_PERF_EN
    logic [31:0]   fetch_cnt;
    logic [31:0]   stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_mw #(.I_DATA_WIDTH(DW), .I_ADDR_WIDTH(AW), .NUM_WARPS(NW)) dut (
        .clk(clk), .rst(rst), .we(we), .pc_w(pc_w), .instr_i(instr_i),
        .start_valid(start_valid), .start_warp(start_warp), .start_pc(start_pc),
        .done_valid(done_valid), .done_warp(done_warp),
        .redir_valid(redir_valid), .redir_warp(redir_warp), .redir_pc(redir_pc),
        .out_ready(out_ready), .out_valid(out_valid), .instr_f(instr_f),
        .warp_f(warp_f), .pc_f(pc_f), .pc_p1(pc_p1), .active_mask(active_mask)
`ifdef FETCH_PERF_EN
        , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
    );

    function automatic logic [31:0] exp_instr(input int a);
        if (a == 0) return 32'h11;
        if (a == 1) return 32'h22;
        if (a == 2) return 32'h33;
        return 32'hC0DE_0000 | a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        we = 1'b1; pc_w = AW'(a); instr_i = d;
        tick();
        we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; pc_w = '0; instr_i = '0;
        start_valid = 1'b0; start_warp = '0; start_pc = '0;
        done_valid = 1'b0; done_warp = '0;
        redir_valid = 1'b0; redir_warp = '0; redir_pc = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_mask", 32'(active_mask), 32'd0);
        chk("rst_pc_f", 32'(pc_f), 32'd0);
        chk("rst_pc_p1", 32'(pc_p1), 32'd0);
        chk("rst_warp_f", 32'(warp_f), 32'd0);
        rst = 1'b0;

        for (int a = 0; a < 64; a++) wr(a, exp_instr(a));
        wr(1023, exp_instr(1023));

        // Single warp sequential fetch
        out_ready = 1'b1;
        start_valid = 1'b1; start_warp = 2'd0; start_pc = 10'd0;
        tick();
        start_valid = 1'b0;
        chk("t1_mask", 32'(active_mask), 32'h1);
        chk("t1_idle", 32'(out_valid), 32'd0);
        for (int n = 0; n < 3; n++) begin
            if (n == 2) begin
                tick();
                done_valid = 1'b1; done_warp = 2'd0;
            end else begin
                tick();
            end
            chk("t1_valid", 32'(out_valid), 32'd1);
            chk("t1_instr", instr_f, exp_instr(n));
            chk("t1_pc_f", 32'(pc_f), 32'(n));
            chk("t1_pc_p1", 32'(pc_p1), 32'(n + 1));
        end
        tick();
        done_valid = 1'b0;
        chk("t1_done_valid", 32'(out_valid), 32'd0);
        chk("t1_done_mask", 32'(active_mask), 32'h0);

        // Four warps, round robin from warp 0 after reset
        do_reset();
        we = 1'b1; pc_w = 10'd0; instr_i = 32'h11;
        for (int w = 0; w < 4; w++) begin
            start_valid = 1'b1; start_warp = WB'(w); start_pc = AW'(w * 8);
            tick();
        end
        we = 1'b0; start_valid = 1'b0;
        chk("t2_mask", 32'(active_mask), 32'hF);
        chk("t2_noissue", 32'(out_valid), 32'd0);
        for (int n = 0; n < 5; n++) begin
            int ew;
            int ep;
            ew = n % 4;
            ep = (n == 4) ? 1 : n * 8;
            tick();
            chk("t2_warp", 32'(warp_f), 32'(ew));
            chk("t2_pc", 32'(pc_f), 32'(ep));
            chk("t2_instr", instr_f, exp_instr(ep));
        end

        // Three-cycle stall holds everything
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("t3_valid", 32'(out_valid), 32'd1);
            chk("t3_warp", 32'(warp_f), 32'd0);
            chk("t3_pc", 32'(pc_f), 32'd1);
            chk("t3_pc_p1", 32'(pc_p1), 32'd2);
            chk("t3_instr", instr_f, 32'h22);
        end
`ifdef FETCH_PERF_EN
        chk("t3_stall_cnt", stall_cnt, 32'd3);
`endif
        out_ready = 1'b1;
        tick();
        chk("t3_next_warp", 32'(warp_f), 32'd1);
        chk("t3_next_pc", 32'(pc_f), 32'd9);
`ifdef FETCH_PERF_EN
        chk("t3_fetch_cnt", fetch_cnt, 32'd5);
`endif

        // Redirect at issue, then redirect of a held instruction
        do_reset();
        start_valid = 1'b1; start_warp = 2'd0; start_pc = 10'd5;
        tick();
        start_valid = 1'b0;
        redir_valid = 1'b1; redir_warp = 2'd0; redir_pc = 10'd40;
        tick();
        redir_valid = 1'b0;
        chk("t4_squash_issue", 32'(out_valid), 32'd0);
        tick();
        chk("t4_valid40", 32'(out_valid), 32'd1);
        chk("t4_pc40", 32'(pc_f), 32'd40);
        chk("t4_instr40", instr_f, exp_instr(40));
        out_ready = 1'b0;
        tick();
        chk("t4_hold40", 32'(pc_f), 32'd40);
        redir_valid = 1'b1; redir_warp = 2'd0; redir_pc = 10'd5;
        tick();
        redir_valid = 1'b0;
        chk("t4_squash_held", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("t4_valid5", 32'(out_valid), 32'd1);
        chk("t4_pc5", 32'(pc_f), 32'd5);
        chk("t4_instr5", instr_f, exp_instr(5));

        // PC wrap at top of address space
        do_reset();
        start_valid = 1'b1; start_warp = 2'd0; start_pc = 10'd1023;
        tick();
        start_valid = 1'b0;
        tick();
        chk("t5_pc_top", 32'(pc_f), 32'd1023);
        chk("t5_pc_p1_wrap", 32'(pc_p1), 32'd0);
        chk("t5_instr_top", instr_f, exp_instr(1023));
        tick();
        chk("t5_pc_wrap", 32'(pc_f), 32'd0);
        chk("t5_pc_p1", 32'(pc_p1), 32'd1);
        chk("t5_instr0", instr_f, 32'h11);

        // Reset during a stall, RAM survives
        out_ready = 1'b0;
        tick();
        chk("t6_stalled", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_mask", 32'(active_mask), 32'h0);
        chk("t6_rst_pc_f", 32'(pc_f), 32'd0);
        chk("t6_rst_pc_p1", 32'(pc_p1), 32'd0);
        out_ready = 1'b1;
        start_valid = 1'b1; start_warp = 2'd0; start_pc = 10'd2;
        tick();
        start_valid = 1'b0;
        tick();
        chk("t6_instr", instr_f, 32'h33);
        chk("t6_pc", 32'(pc_f), 32'd2);

        // Start and done on the same warp keep it active
        start_valid = 1'b1; start_warp = 2'd1; start_pc = 10'd3;
        done_valid = 1'b1; done_warp = 2'd1;
        tick();
        start_valid = 1'b0; done_valid = 1'b0;
        chk("t7_mask", 32'(active_mask), 32'h3);
        chk("t7_w0_pc", 32'(pc_f), 32'd3);
        tick();
        chk("t7_w1_warp", 32'(warp_f), 32'd1);
        chk("t7_w1_pc", 32'(pc_f), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
